reorder_issue_arbiter: RTL and testbench
========================================

Name: reorder_issue_arbiter

Overview:
Shares one reorder_queue instance between NUM_REQ read requesters. Each cycle it grants at most one requester, round-robin. A grant pulses the queue's increment and stamps the outgoing memory request with the queue's index_tag. The requester ID is kept in an in-order ID FIFO, so in-order responses leaving the queue are steered back to the requester that issued them.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_WIDTH, 2, requester ID width; must be ≥ log2(NUM_REQ).
- ADDR_WIDTH, 48, request address width.
- DATA_WIDTH, 64, response payload width (reorder_queue WIDTH).
- DEPTH, 32, reorder_queue DEPTH; also the ID FIFO depth; power of two.
- TAG_WIDTH, 6, equals reorder_queue ADDR_DEPTH_WIDTH+1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- req, input, NUM_REQ, per-requester request valid; held until granted.
- req_addr, input, NUM_REQ*ADDR_WIDTH, packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- grant, output, NUM_REQ, combinational one-hot accept, same cycle as req.
- mem_req, output, 1, registered issue pulse to memory.
- mem_addr, output, ADDR_WIDTH, registered address of the issued request.
- mem_tag, output, TAG_WIDTH, registered tag; memory returns it in the reorder_queue d index field.
- mem_stall, input, 1, memory backpressure; blocks new grants.
- rq_increment, output, 1, combinational; drives reorder_queue increment.
- rq_index_tag, input, TAG_WIDTH, from reorder_queue index_tag.
- rq_full, input, 1, from reorder_queue full.
- rq_valid, input, 1, from reorder_queue valid.
- rq_q, input, DATA_WIDTH, from reorder_queue q.
- rsp_valid, output, NUM_REQ, registered one-hot response strobe.
- rsp_data, output, DATA_WIDTH, registered response payload.
- idle, output, 1, high when INIT is done, no requests are outstanding and mem_req is low.
- err_underflow, output, 1, sticky: rq_valid arrived with the ID FIFO empty.

Behaviour:
- States: INIT and RUN. rst forces INIT from any state, including mid-operation.
- INIT
  - Covers the reorder_queue's own reset sweep.
  - init_cnt loads 0 on rst and counts to DEPTH+1, then moves to RUN.
  - No grants in INIT. rq_valid is ignored.
- Reset values (registered): mem_req=0, mem_addr=0, mem_tag=0, rsp_valid=0, rsp_data=0, err_underflow=0, idle=0.
- Internal reset: ID FIFO empty, outstanding=0, rr_ptr=0.
- Grant condition in RUN: |req && !rq_full && !mem_stall && !id_fifo_full.
- Arbitration
  - Round-robin starting at rr_ptr, wrapping modulo NUM_REQ.
  - The winner k gets grant[k]=1 and rq_increment=1 in the same cycle.
  - rr_ptr <= k+1 (mod NUM_REQ). rr_ptr is unchanged when nothing is granted.
- Issue
  - On grant, the next cycle has mem_req=1, mem_addr=req_addr[k], and mem_tag = rq_index_tag sampled in the grant cycle (the pre-increment value).
  - mem_req is a single-cycle pulse. Downstream accepts it unconditionally.
- ID FIFO
  - DEPTH entries of ID_WIDTH bits, with extra-bit pointers for full/empty.
  - Push k on grant. Pop on rq_valid.
  - Push and pop in the same cycle are both performed.
  - A push while full is impossible, because the grant condition excludes it.
- Response path
  - One cycle after rq_valid: rsp_valid = 1<<head_id and rsp_data = rq_q. Otherwise rsp_valid=0.
  - rsp_data holds its last value when rsp_valid=0.
- Underflow: rq_valid with the FIFO empty sets err_underflow (cleared only by rst), produces no rsp_valid, and does not move the pointers.
- outstanding: +1 on grant, -1 on a valid pop, net 0 when both occur; width log2(DEPTH)+1.
- rq_full high means no grant that cycle, even with requests pending.
- Back-to-back grants: one per cycle, with consecutive tags wrapping modulo 2^TAG_WIDTH.

Optional Feature:
- Macro: REORDER_ISSUE_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_count (NUM_REQ*32): per-requester 32-bit grant counters.
  - Adds output block_count (32): cycles where |req was high in RUN but no grant occurred.
  - All counters wrap, and reset to 0 on rst.
- When undefined: neither port nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset/INIT: rst 1 cycle, req=4'b1111 → grant=0 for DEPTH+1=33 cycles. First grant=4'b0001 on cycle 34 with mem_tag equal to the rq_index_tag at that cycle.
- Round-robin: req=4'b1111 held 8 cycles, no stall → grants 0001,0010,0100,1000,0001,... Tags are consecutive, and mem_req follows each grant by 1 cycle.
- Backpressure: mem_stall=1 for 3 cycles with req=4'b0100, then rq_full=1 for 2 cycles → grant=0 and rq_increment=0 during both periods. grant=0100 on the first cycle with both low.
- Response steering: grant r2, r0, r3, then rq_valid 3 times with rq_q=0xA,0xB,0xC → rsp_valid=0100/0xA, 0001/0xB, 1000/0xC, each 1 cycle after rq_valid. idle=1 afterwards.
- Simultaneous push/pop and full: fill 32 outstanding → grant blocked. Then grant and rq_valid in the same cycle → outstanding unchanged and FIFO order preserved.
- Underflow and mid-run reset: rq_valid with the FIFO empty → err_underflow=1 and rsp_valid=0. rst asserted with 5 outstanding → FIFO empty, err_underflow=0, INIT re-entered.

Source files
------------

// File: rtl/reorder_issue_arbiter_if.sv
// rtl/reorder_issue_arbiter_if.sv - requester, memory-issue and reorder-queue signal bundle for reorder_issue_arbiter
// Optional statistics outputs exist only when REORDER_ISSUE_ARBITER_STATS_EN is defined.
interface reorder_issue_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 6
);
    // requester side
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            grant;
    // memory issue side
    logic                          mem_req;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [TAG_WIDTH-1:0]          mem_tag;
    logic                          mem_stall;
    // reorder_queue side
    logic                          rq_increment;
    logic [TAG_WIDTH-1:0]          rq_index_tag;
    logic                          rq_full;
    logic                          rq_valid;
    logic [DATA_WIDTH-1:0]         rq_q;
    // response side
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    // status
    logic                          idle;
    logic                          err_underflow;
`ifdef REORDER_ISSUE_ARBITER_STATS_EN
    logic [NUM_REQ*32-1:0]         grant_count;
    logic [31:0]                   block_count;
`endif

    // arbiter side
    modport slave (
`ifdef REORDER_ISSUE_ARBITER_STATS_EN
        output grant_count, output block_count,
`endif
        input  req, input req_addr, input mem_stall,
        input  rq_index_tag, input rq_full, input rq_valid, input rq_q,
        output grant, output mem_req, output mem_addr, output mem_tag,
        output rq_increment, output rsp_valid, output rsp_data,
        output idle, output err_underflow
    );

    // environment side (requesters, memory, reorder_queue)
    modport master (
`ifdef REORDER_ISSUE_ARBITER_STATS_EN
        input  grant_count, input block_count,
`endif
        output req, output req_addr, output mem_stall,
        output rq_index_tag, output rq_full, output rq_valid, output rq_q,
        input  grant, input mem_req, input mem_addr, input mem_tag,
        input  rq_increment, input rsp_valid, input rsp_data,
        input  idle, input err_underflow
    );
endinterface

// File: rtl/reorder_issue_arbiter.sv
// rtl/reorder_issue_arbiter.sv - round-robin issue arbiter sharing one reorder_queue, with in-order response steering
// Optional macro REORDER_ISSUE_ARBITER_STATS_EN adds per-requester grant counters and a blocked-cycle counter.
module reorder_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 32,
    parameter int TAG_WIDTH  = 6
) (
    input logic                 clk,
    input logic                 rst,
    reorder_issue_arbiter_if.slave bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 2);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEPTH);

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

    // ID FIFO: extra-bit pointers distinguish full from empty
    logic [ID_WIDTH-1:0]   fifo_mem_q [DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        outstanding;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ID_WIDTH-1:0]   head_id;

    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [TAG_WIDTH-1:0]  mem_tag_q, mem_tag_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  idle_q, idle_d;
    logic                  err_q, err_d;

    logic                  can_grant;
    logic                  granted;
    logic [ID_WIDTH-1:0]   win_id;
    logic [NUM_REQ-1:0]    grant_vec;
    logic                  pop;
    logic                  underflow;

    assign outstanding = wr_ptr_q - rd_ptr_q;
    assign fifo_full   = (outstanding == FULL_CNT);
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign head_id     = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    // Rotating-priority search for the first requester at or after rr_ptr
    always_comb begin
        int idx;
        grant_vec = '0;
        win_id    = '0;
        granted   = 1'b0;
        can_grant = !rst && (state_q == ST_RUN) && (|bus.req) && !bus.rq_full
                    && !bus.mem_stall && !fifo_full;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (can_grant && !granted && bus.req[idx]) begin
                granted        = 1'b1;
                win_id         = idx[ID_WIDTH-1:0];
                grant_vec[idx] = 1'b1;
            end
        end
    end

    assign bus.grant        = grant_vec;
    assign bus.rq_increment = granted;

    // Response pop versus underflow is decided on the pre-cycle FIFO occupancy
    assign pop       = !rst && (state_q == ST_RUN) && bus.rq_valid && !fifo_empty;
    assign underflow = !rst && (state_q == ST_RUN) && bus.rq_valid && fifo_empty;

    // Next-state for control, FIFO pointers, issue and response registers
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_req_d   = granted;
        mem_addr_d  = mem_addr_q;
        mem_tag_d   = mem_tag_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q || underflow;

        // INIT waits out the reorder_queue's own reset sweep
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == INIT_LAST) begin
                state_d = ST_RUN;
            end
        end

        if (granted) begin
            mem_addr_d = bus.req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_tag_d  = bus.rq_index_tag;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            if (int'(win_id) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_id + 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            rsp_valid_d = NUM_REQ'(1) << head_id;
            rsp_data_d  = bus.rq_q;
        end

        idle_d = (state_d == ST_RUN) && (wr_ptr_d == rd_ptr_d) && !mem_req_d;
    end

    // Control and datapath registers with synchronous reset back to INIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            idle_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_tag_q   <= mem_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
        end
    end

    // ID FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (granted) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= win_id;
        end
    end

    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_tag       = mem_tag_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.idle          = idle_q;
    assign bus.err_underflow = err_q;

`ifdef REORDER_ISSUE_ARBITER_STATS_EN
    logic [31:0] grant_count_q [NUM_REQ];
    logic [31:0] block_count_q;

    // Wrapping per-requester grant counters and blocked-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_count_q[i] <= '0;
            end
            block_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_vec[i]) begin
                    grant_count_q[i] <= grant_count_q[i] + 1'b1;
                end
            end
            if ((state_q == ST_RUN) && (|bus.req) && !granted) begin
                block_count_q <= block_count_q + 1'b1;
            end
        end
    end

    // Flatten counters onto the packed output
    always_comb begin
        bus.grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.grant_count[i*32 +: 32] = grant_count_q[i];
        end
    end

    assign bus.block_count = block_count_q;
`endif

endmodule

// File: tb/tb_reorder_issue_arbiter.sv
// tb/tb_reorder_issue_arbiter.sv - randomized self-checking bench for reorder_issue_arbiter against a queue-based model
module tb_reorder_issue_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int ADDR_WIDTH = 48;
    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 32;
    localparam int TAG_WIDTH  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_issue_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) bus ();

    reorder_issue_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: FIFO of requester ids, rotating pointer, cycle count since reset
    int               mq[$];
    int               rr;
    int               cyc;
    logic [TAG_WIDTH-1:0] tag_ctr;
    logic [NUM_REQ-1:0]   req_r;
    logic [63:0]          addr_r [NUM_REQ];

    logic                 e_mem_req;
    logic [63:0]          e_mem_addr;
    logic [63:0]          e_mem_tag;
    logic [NUM_REQ-1:0]   e_rsp_valid;
    logic [63:0]          e_rsp_data;
    logic                 e_idle;
    logic                 e_err;

    task automatic model_reset();
        mq.delete();
        rr          = 0;
        cyc         = 0;
        tag_ctr     = '0;
        e_mem_req   = 1'b0;
        e_mem_addr  = '0;
        e_mem_tag   = '0;
        e_rsp_valid = '0;
        e_rsp_data  = '0;
        e_idle      = 1'b0;
        e_err       = 1'b0;
    endtask

    task automatic step(input bit do_rst, input int p_req, input int p_stall,
                        input int p_full, input int p_valid, input bit allow_uf);
        logic [63:0] r64;
        logic        stall, full, valid;
        logic [63:0] data;
        int          g;
        bit          run;

        @(posedge clk);
        #1;
        chk("mem_req",   {63'd0, bus.mem_req},        {63'd0, e_mem_req});
        chk("mem_addr",  {16'd0, bus.mem_addr},       e_mem_addr);
        chk("mem_tag",   {58'd0, bus.mem_tag},        e_mem_tag);
        chk("rsp_valid", {60'd0, bus.rsp_valid},      {60'd0, e_rsp_valid});
        chk("rsp_data",  bus.rsp_data,                e_rsp_data);
        chk("idle",      {63'd0, bus.idle},           {63'd0, e_idle});
        chk("err_uf",    {63'd0, bus.err_underflow},  {63'd0, e_err});

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_r[i] && ($urandom_range(99) < p_req)) begin
                req_r[i]  = 1'b1;
                r64       = {$urandom, $urandom};
                addr_r[i] = {16'd0, r64[47:0]};
            end
        end
        stall = ($urandom_range(99) < p_stall);
        full  = ($urandom_range(99) < p_full);
        valid = ($urandom_range(99) < p_valid) && (allow_uf || mq.size() > 0);
        data  = {$urandom, $urandom};

        rst              = do_rst;
        bus.req          = req_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_r[i][ADDR_WIDTH-1:0];
        end
        bus.mem_stall    = stall;
        bus.rq_full      = full;
        bus.rq_valid     = valid;
        bus.rq_q         = data;
        bus.rq_index_tag = tag_ctr;
        #1;

        run = (cyc >= DEPTH + 1);
        g = -1;
        if (!do_rst && run && req_r != 0 && !full && !stall && mq.size() < DEPTH) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g < 0 && req_r[(rr + i) % NUM_REQ]) begin
                    g = (rr + i) % NUM_REQ;
                end
            end
        end
        chk("grant",  {60'd0, bus.grant},         (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("rq_inc", {63'd0, bus.rq_increment}, {63'd0, (g >= 0)});

        if (do_rst) begin
            model_reset();
        end else begin
            e_rsp_valid = '0;
            if (run && valid) begin
                if (mq.size() > 0) begin
                    e_rsp_valid = NUM_REQ'(1) << mq.pop_front();
                    e_rsp_data  = data;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_mem_req = (g >= 0);
            if (g >= 0) begin
                e_mem_addr = addr_r[g];
                e_mem_tag  = {58'd0, tag_ctr};
                tag_ctr    = tag_ctr + 1'b1;
                mq.push_back(g);
                rr       = (g + 1) % NUM_REQ;
                req_r[g] = 1'b0;
            end
            cyc++;
            e_idle = (cyc >= DEPTH + 1) && (mq.size() == 0) && (g < 0);
        end
    endtask

    task automatic phase(input int n, input int p_req, input int p_stall,
                         input int p_full, input int p_valid, input bit allow_uf);
        for (int k = 0; k < n; k++) begin
            step(1'b0, p_req, p_stall, p_full, p_valid, allow_uf);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.req          = '0;
        bus.req_addr     = '0;
        bus.mem_stall    = 1'b0;
        bus.rq_full      = 1'b0;
        bus.rq_valid     = 1'b0;
        bus.rq_q         = '0;
        bus.rq_index_tag = '0;
        req_r            = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_r[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);

        step(1'b1, 100, 0, 0, 0, 1'b0);
        // INIT with all requesters asking, then round-robin with no stalls
        phase(50, 100, 0, 0, 0, 1'b0);
        // mixed traffic with stall and full backpressure
        phase(300, 50, 15, 15, 40, 1'b0);
        // fill the ID FIFO until grants block
        phase(60, 100, 0, 0, 0, 1'b0);
        // concurrent push/pop near full
        phase(150, 100, 5, 5, 50, 1'b0);
        // drain to idle
        phase(50, 0, 0, 0, 100, 1'b0);
        phase(5, 0, 0, 0, 0, 1'b0);
        // underflow
        phase(10, 0, 0, 0, 50, 1'b1);
        // a few grants, then reset mid-run with requests outstanding
        phase(6, 100, 0, 0, 0, 1'b0);
        step(1'b1, 100, 0, 0, 0, 1'b0);
        phase(45, 100, 0, 0, 0, 1'b0);
        phase(200, 60, 10, 10, 45, 1'b0);
        phase(3, 0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
